// File: rtl/spiker_run_ctrl.sv
// spiker_run_ctrl: loads N_IN_WORDS words into the core, issues watchdog-guarded timesteps, then triggers result capture (ports: start/abort/num_steps in, core load/step handshakes, writer handshake, busy/ready/error status)
module spiker_run_ctrl #(
  parameter int WIDTH      = 32,
  parameter int N_IN_WORDS = 25,
  parameter int STEP_W     = 16,
  parameter int TIMEOUT_W  = 20
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [STEP_W-1:0]             num_steps_i,
  input  logic [WIDTH-1:0]              in_word_i,
  output logic [$clog2(N_IN_WORDS)-1:0] in_idx_o,
  output logic [WIDTH-1:0]              core_data_o,
  output logic                          core_wr_o,
  input  logic                          core_ready_i,
  output logic                          core_step_o,
  input  logic                          core_step_done_i,
  output logic                          sample_o,
  input  logic                          writer_ready_i,
  output logic                          busy_o,
  output logic                          ready_o,
  output logic                          error_o
);
  localparam int IDX_W = $clog2(N_IN_WORDS);
  typedef enum logic [2:0] {IDLE, LOAD, STEP, WAIT_STEP, SAMPLE, WAIT_WR, DONE, ERR} state_t;
  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [STEP_W-1:0]    steps_q, steps_d, cnt_q, cnt_d, cnt_inc;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic                 ready_q, ready_d, error_q, error_d;
  assign cnt_inc     = cnt_q + 1'b1;
  assign wd_inc      = wd_q + 1'b1;
  assign busy_o      = state_q inside {LOAD, STEP, WAIT_STEP, SAMPLE, WAIT_WR};
  assign core_wr_o   = state_q == LOAD;
  assign core_step_o = state_q == STEP;
  assign sample_o    = state_q == SAMPLE;
  assign core_data_o = core_wr_o ? in_word_i : '0;
  assign in_idx_o    = idx_q;
  assign ready_o     = ready_q;
  assign error_o     = error_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    steps_d = steps_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    ready_d = ready_q;
    error_d = error_q;
    if (busy_o && abort_i) begin
      state_d = IDLE;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          if (num_steps_i != '0) begin
            state_d = LOAD;
            idx_d   = '0;
            cnt_d   = '0;
            steps_d = num_steps_i;
            ready_d = 1'b0;
            error_d = 1'b0;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
        LOAD: if (core_ready_i) begin
          idx_d   = idx_q == IDX_W'(N_IN_WORDS - 1) ? '0 : idx_q + 1'b1;
          state_d = idx_q == IDX_W'(N_IN_WORDS - 1) ? STEP : LOAD;
        end
        STEP: begin
          wd_d    = '0;
          state_d = WAIT_STEP;
        end
        WAIT_STEP: if (core_step_done_i) begin
          cnt_d   = cnt_inc;
          state_d = cnt_inc == steps_q ? SAMPLE : STEP;
        end else begin
          wd_d    = wd_inc;
          state_d = &wd_inc ? ERR : WAIT_STEP;
          error_d = error_q | (&wd_inc);
        end
        SAMPLE: begin
          wd_d    = '0;
          state_d = WAIT_WR;
        end
        WAIT_WR: if (writer_ready_i) begin
          state_d = DONE;
          ready_d = 1'b1;
        end else begin
          wd_d    = wd_inc;
          state_d = &wd_inc ? ERR : WAIT_WR;
          error_d = error_q | (&wd_inc);
        end
        DONE: state_d = IDLE;
        ERR: begin
          error_d = 1'b1;
          state_d = abort_i ? IDLE : ERR;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      steps_q <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      steps_q <= steps_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end
endmodule
